// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//
// Bridges a valid/ready request/response channel pair onto an APB4 master
// port. One command is accepted in IDLE, the transfer runs as SETUP then
// ACCESS (held until PREADY), and the result is presented on the response
// channel until consumed. Only one transfer is ever in flight.
//
// Optional feature macro:
//   APB_TIMEOUT_EN - when defined, an ACCESS phase that sees no PREADY by its
//                    TIMEOUT-th cycle is terminated and answered with
//                    slverr=1 / rdata=0. When undefined, ACCESS waits
//                    indefinitely and TIMEOUT is unused.
//
// Parameters:
//   AWIDTH   APB address width
//   DWIDTH   APB data width
//   SWIDTH   write-strobe width (DWIDTH/8)
//   TIMEOUT  ACCESS-phase cycle limit (>= 2), timeout build only
//
// Ports:
//   i_ck, i_rst                 clock (posedge), synchronous active-high reset
//   i_req_valid / o_req_ready   request handshake
//   i_req_write/addr/wdata/strb/prot  request command fields
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_rdata, o_rsp_slverr   response payload (0 while o_rsp_valid=0)
//   o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot
//                               APB master outputs (0 outside SETUP/ACCESS)
//   i_prdata, i_pready, i_pslverr  APB slave returns (sampled in ACCESS only)
// ---------------------------------------------------------------------------
module apb_req_master #(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int SWIDTH  = DWIDTH / 8,
  parameter int TIMEOUT = 16
) (
  input  logic              i_ck,
  input  logic              i_rst,
  // request channel
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  input  logic [SWIDTH-1:0] i_req_strb,
  input  logic [2:0]        i_req_prot,
  // response channel
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DWIDTH-1:0] o_rsp_rdata,
  output logic              o_rsp_slverr,
  // APB master port
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [AWIDTH-1:0] o_paddr,
  output logic [DWIDTH-1:0] o_pwdata,
  output logic [SWIDTH-1:0] o_pstrb,
  output logic [2:0]        o_pprot,
  input  logic [DWIDTH-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_req_master: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched command. Data-path only: the FSM gates every use, so no reset.
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  logic [SWIDTH-1:0] cmd_strb;
  logic [2:0]        cmd_prot;

  // Captured response payload.
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              rsp_slverr_q;

  logic req_take;
  logic access_done;
  logic timeout_hit;

  assign req_take    = (state == IDLE) && i_req_valid;
  assign access_done = (state == ACCESS) && i_pready;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] acc_cnt;

  // Counts completed ACCESS cycles; zero during the first ACCESS cycle, so
  // the TIMEOUT-th cycle is the one where acc_cnt == TIMEOUT-1. PREADY on
  // that cycle still completes normally because access_done is checked first.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      acc_cnt <= '0;
    end else if (state != ACCESS) begin
      acc_cnt <= '0;
    end else begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !i_pready &&
                       (acc_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture at acceptance; strobes are meaningless for reads.
  always_ff @(posedge i_ck) begin
    if (req_take) begin
      cmd_write <= i_req_write;
      cmd_addr  <= i_req_addr;
      cmd_wdata <= i_req_wdata;
      cmd_strb  <= i_req_write ? i_req_strb : '0;
      cmd_prot  <= i_req_prot;
    end
  end

  // Response capture at the end of ACCESS
  always_ff @(posedge i_ck) begin
    if (access_done) begin
      rsp_rdata_q  <= cmd_write ? '0 : i_prdata;
      rsp_slverr_q <= i_pslverr;
    end else if (timeout_hit) begin
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b1;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt    = state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_rdata  = '0;
    o_rsp_slverr = 1'b0;
    o_psel       = 1'b0;
    o_penable    = 1'b0;
    o_pwrite     = 1'b0;
    o_paddr      = '0;
    o_pwdata     = '0;
    o_pstrb      = '0;
    o_pprot      = 3'd0;

    unique case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        o_psel    = 1'b1;
        o_pwrite  = cmd_write;
        o_paddr   = cmd_addr;
        o_pwdata  = cmd_wdata;
        o_pstrb   = cmd_strb;
        o_pprot   = cmd_prot;
        state_nxt = ACCESS;
      end

      ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        o_pwrite  = cmd_write;
        o_paddr   = cmd_addr;
        o_pwdata  = cmd_wdata;
        o_pstrb   = cmd_strb;
        o_pprot   = cmd_prot;
        if (access_done || timeout_hit) begin
          state_nxt = RESP;
        end
      end

      RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_rdata  = rsp_rdata_q;
        o_rsp_slverr = rsp_slverr_q;
        if (i_rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

  localparam int AWIDTH  = 12;
  localparam int DWIDTH  = 32;
  localparam int SWIDTH  = DWIDTH / 8;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [SWIDTH-1:0] req_strb;
  logic [2:0]        req_prot;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DWIDTH-1:0] pwdata;
  logic [SWIDTH-1:0] pstrb;
  logic [2:0]        pprot;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int checks = 0;
  int errors = 0;

  // Reference slave memory: address -> word, unwritten words read as 0.
  logic [31:0] mem [logic [11:0]];

  apb_req_master #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .SWIDTH (SWIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_ck        (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_strb  (req_strb),
    .i_req_prot  (req_prot),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_slverr(rsp_slverr),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .o_pstrb     (pstrb),
    .o_pprot     (pprot),
    .i_prdata    (prdata),
    .i_pready    (pready),
    .i_pslverr   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [11:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic check_apb_idle(input string tag);
    chk({tag, "_psel"},    psel,    1'b0);
    chk({tag, "_penable"}, penable, 1'b0);
    chk({tag, "_paddr"},   paddr,   '0);
    chk({tag, "_pwdata"},  pwdata,  '0);
    chk({tag, "_pstrb"},   pstrb,   '0);
    chk({tag, "_pprot"},   pprot,   '0);
    chk({tag, "_pwrite"},  pwrite,  1'b0);
  endtask

  task automatic check_apb_cmd(input string tag, input logic w, input logic [11:0] a,
                               input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    chk({tag, "_paddr"},  paddr,  a);
    chk({tag, "_pwrite"}, pwrite, w);
    chk({tag, "_pwdata"}, pwdata, wd);
    chk({tag, "_pstrb"},  pstrb,  w ? st : 4'h0);
    chk({tag, "_pprot"},  pprot,  pr);
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr);
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_rsp_valid", rsp_valid, 1'b0);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = st;
    req_prot  = pr;
    step();
    // Scramble the request bus after acceptance: the DUT must hold its copy.
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = AWIDTH'($urandom);
    req_wdata = $urandom;
    req_strb  = SWIDTH'($urandom);
    req_prot  = 3'($urandom);
  endtask

  // One complete transfer: waits = ACCESS cycles with pready=0 before the
  // completing cycle, rdly = RESP cycles with rsp_ready=0 before consumption.
  task automatic do_xfer(input logic w, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr,
                         input int waits, input logic err, input int rdly);
    logic [31:0] slv;
    logic [31:0] exp_rd;
    logic [31:0] nv;
    slv    = mem_rd(a);
    exp_rd = w ? 32'h0 : slv;

    issue(w, a, wd, st, pr);

    // N+1: SETUP. Slave lines are set to active values that must be ignored.
    chk("setup_psel",      psel,      1'b1);
    chk("setup_penable",   penable,   1'b0);
    chk("setup_req_ready", req_ready, 1'b0);
    chk("setup_rsp_valid", rsp_valid, 1'b0);
    check_apb_cmd("setup", w, a, wd, st, pr);
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = $urandom;
    step();

    // N+2 onward: ACCESS
    for (int k = 0; k <= waits; k++) begin
      chk("access_psel",      psel,      1'b1);
      chk("access_penable",   penable,   1'b1);
      chk("access_rsp_valid", rsp_valid, 1'b0);
      chk("access_req_ready", req_ready, 1'b0);
      check_apb_cmd("access", w, a, wd, st, pr);
      pready  = (k == waits);
      pslverr = (k == waits) ? err : 1'($urandom);
      prdata  = (k == waits) ? slv : $urandom;
      step();
    end

    // RESP: slave lines toggle freely and must not matter.
    for (int d = 0; d <= rdly; d++) begin
      pready    = 1'($urandom);
      pslverr   = 1'($urandom);
      prdata    = $urandom;
      chk("resp_valid",     rsp_valid,  1'b1);
      chk("resp_rdata",     rsp_rdata,  exp_rd);
      chk("resp_slverr",    rsp_slverr, err);
      chk("resp_req_ready", req_ready,  1'b0);
      check_apb_idle("resp");
      rsp_ready = (d == rdly);
      req_valid = (d < rdly) ? 1'($urandom) : 1'b0;
      step();
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    chk("post_rsp_valid",  rsp_valid,  1'b0);
    chk("post_rsp_rdata",  rsp_rdata,  32'h0);
    chk("post_rsp_slverr", rsp_slverr, 1'b0);
    chk("post_req_ready",  req_ready,  1'b1);
    check_apb_idle("post");

    if (w && !err) begin
      nv = mem_rd(a);
      for (int b = 0; b < 4; b++) if (st[b]) nv[8*b +: 8] = wd[8*b +: 8];
      mem[a] = nv;
    end
  endtask

  task automatic reset_mid_access();
    issue(1'b1, 12'h123, 32'hCAFE_F00D, 4'hF, 3'd2);
    step();
    chk("rst_pre_penable", penable, 1'b1);
    pready = 1'b0;
    rst    = 1'b1;
    step();
    chk("rst_psel",      psel,      1'b0);
    chk("rst_penable",   penable,   1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    step();
    chk("rst_after_rsp_valid", rsp_valid, 1'b0);
    chk("rst_after_req_ready", req_ready, 1'b1);
    check_apb_idle("rst_after");
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic timeout_test();
    int n;
    issue(1'b0, 12'h0F0, 32'h0, 4'h0, 3'd0);
    step();
    pready = 1'b0;
    n = 0;
    while (penable === 1'b1 && n < 100) begin
      n++;
      pslverr = 1'b0;
      prdata  = $urandom;
      step();
    end
    chk("to_access_cycles", n, TIMEOUT);
    chk("to_rsp_valid",  rsp_valid,  1'b1);
    chk("to_rsp_slverr", rsp_slverr, 1'b1);
    chk("to_rsp_rdata",  rsp_rdata,  32'h0);
    check_apb_idle("to_resp");
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_post_req_ready", req_ready, 1'b1);
  endtask
`endif

  initial begin
    logic        w;
    logic [11:0] a;
    logic [3:0]  st;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    step();
    chk("reset_req_ready",  req_ready,  1'b1);
    chk("reset_rsp_valid",  rsp_valid,  1'b0);
    chk("reset_rsp_rdata",  rsp_rdata,  32'h0);
    chk("reset_rsp_slverr", rsp_slverr, 1'b0);
    check_apb_idle("reset");
    step();
    rst = 1'b0;
    step();

    // Directed scenarios
    do_xfer(1'b1, 12'h0A4, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 0);
    do_xfer(1'b0, 12'h0A4, 32'h0,        4'hF, 3'd1, 0, 1'b0, 0);
    do_xfer(1'b1, 12'h0A8, 32'h1234_5678, 4'h5, 3'd3, 3, 1'b0, 0);
    do_xfer(1'b0, 12'h0A8, 32'h0,        4'h0, 3'd0, 3, 1'b0, 0);
    do_xfer(1'b0, 12'h0A4, 32'h0,        4'h0, 3'd4, 0, 1'b1, 0);
    do_xfer(1'b0, 12'h0A4, 32'h0,        4'h0, 3'd0, 0, 1'b0, 0);
    do_xfer(1'b1, 12'h0AC, 32'h0BAD_F00D, 4'hF, 3'd7, 1, 1'b0, 5);
    reset_mid_access();
    do_xfer(1'b0, 12'h0AC, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);

`ifdef APB_TIMEOUT_EN
    timeout_test();
    do_xfer(1'b0, 12'h0A4, 32'h0, 4'h0, 3'd0, TIMEOUT - 1, 1'b0, 0);
`endif

    // Randomized traffic over a small address window so reads hit writes
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      a  = 12'h0A0 + 12'(4 * $urandom_range(0, 7));
      st = 4'($urandom);
      do_xfer(w, a, $urandom, st, 3'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
